// File: rtl/serial_adder_bank.sv
// Bank of LANES independent bit-serial adder/subtractors sharing one controller.
// Each lane consumes one operand bit per clock, LSB first.
module serial_adder_bank #(
    parameter int WIDTH = 8,
    parameter int LANES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    input  logic [LANES-1:0]       cin,
    output logic                   busy,
    output logic                   done,
    output logic [LANES*WIDTH-1:0] sum,
    output logic [LANES-1:0]       cout,
    output logic [LANES-1:0]       ovf
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t state;

    logic [LANES*WIDTH-1:0] a_sh;
    logic [LANES*WIDTH-1:0] b_sh;
    logic [LANES*WIDTH-1:0] res;
    logic [LANES-1:0]       carry;
    logic [CW-1:0]          cnt;

    logic [LANES-1:0]       s_bit;
    logic [LANES-1:0]       c_next;
    logic [LANES*WIDTH-1:0] a_next;
    logic [LANES*WIDTH-1:0] b_next;
    logic [LANES*WIDTH-1:0] res_next;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        s_bit    = '0;
        c_next   = '0;
        a_next   = '0;
        b_next   = '0;
        res_next = '0;
        for (int i = 0; i < LANES; i++) begin
            s_bit[i]  = a_sh[i*WIDTH] ^ b_sh[i*WIDTH] ^ carry[i];
            c_next[i] = (a_sh[i*WIDTH] & b_sh[i*WIDTH]) |
                        (a_sh[i*WIDTH] & carry[i]) |
                        (b_sh[i*WIDTH] & carry[i]);
            a_next[i*WIDTH +: WIDTH]   = {1'b0, a_sh[i*WIDTH+1 +: WIDTH-1]};
            b_next[i*WIDTH +: WIDTH]   = {1'b0, b_sh[i*WIDTH+1 +: WIDTH-1]};
            res_next[i*WIDTH +: WIDTH] = {s_bit[i], res[i*WIDTH+1 +: WIDTH-1]};
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift registers are small flops, not RAM, so they are all cleared on reset.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= '0;
            ovf   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // subtract is a + ~b + ~borrow_in
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        res   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_next;
                    b_sh  <= b_next;
                    res   <= res_next;
                    carry <= c_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        // On the MSB step, carry holds the carry into the MSB; results are
                        // registered here so they become visible during FIN.
                        sum   <= res_next;
                        cout  <= c_next;
                        ovf   <= carry ^ c_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
